// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - scheduled multi-channel fault injector (arm, trigger, delay, inject)
module glitch_sequencer #(
  parameter int          WIDTH     = 32,
  parameter int          CHANNELS  = 2,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  input  logic                      arm,
  input  logic                      trigger,
  input  logic                      abort,
  input  logic [1:0]                cfg_mode,
  input  logic [CHANNELS-1:0]       cfg_chan_mask,
  input  logic [CNT_W-1:0]          cfg_delay,
  input  logic [CNT_W-1:0]          cfg_duration,
  input  logic [WIDTH-1:0]          cfg_pattern,
  output logic                      busy,
  output logic                      glitch_active,
  output logic                      done,
  output logic [7:0]                glitch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_INJECT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      TAPS    = 32'h8020_0003;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [1:0]           sh_mode;
  logic [CHANNELS-1:0]  sh_mask;
  logic [CNT_W-1:0]     sh_delay;
  logic [CNT_W-1:0]     sh_duration;
  logic [WIDTH-1:0]     sh_pattern;
  logic [31:0]          lfsr;
  logic [CNT_W-1:0]     dur_m1;

  // A zero duration still produces a single glitched cycle.
  assign dur_m1 = (sh_duration == '0) ? '0 : sh_duration - CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sh_mode      <= '0;
      sh_mask      <= '0;
      sh_delay     <= '0;
      sh_duration  <= '0;
      sh_pattern   <= '0;
      lfsr         <= LFSR_SEED;
      glitch_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && arm) begin
        sh_mode     <= cfg_mode;
        sh_mask     <= cfg_chan_mask;
        sh_delay    <= cfg_delay;
        sh_duration <= cfg_duration;
        sh_pattern  <= cfg_pattern;
      end
      lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
      if (state == S_DONE && glitch_count != 8'hFF)
        glitch_count <= glitch_count + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (arm) state_nx = S_ARMED;
      end
      S_ARMED: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (trigger) begin
          cnt_nx   = sh_delay;
          state_nx = S_DELAY;
        end
      end
      S_DELAY: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (cnt == '0) begin
          cnt_nx   = dur_m1;
          state_nx = S_INJECT;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      S_INJECT: begin
        if (abort)            state_nx = S_IDLE;
        else if (cnt == '0)   state_nx = S_DONE;
        else                  cnt_nx   = cnt - CNT_ONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy          = (state != S_IDLE);
  assign glitch_active = (state == S_INJECT);
  assign done          = (state == S_DONE);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] rnd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    // Each channel sees the LFSR rotated by a further byte.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign rnd[i] = lfsr[(i + 8 * c) % 32];
    end

    assign din = data_in[c*WIDTH +: WIDTH];

    always_comb begin
      dout = din;
      if (glitch_active && sh_mask[c]) begin
        case (sh_mode)
          2'd0:    dout = sh_pattern;
          2'd1:    dout = din ^ sh_pattern;
          2'd2:    dout = rnd;
          default: dout = din ^ (rnd & sh_pattern);
        endcase
      end
    end

    assign data_out[c*WIDTH +: WIDTH] = dout;
  end

endmodule

// File: doc/glitch_sequencer.md
# glitch_sequencer

Multi-channel, synthesizable fault-injection block placed inline on one or more datapath buses between the two RISC-V cores and their shared resources. It injects a scheduled glitch: armed, triggered, delayed by a programmable number of cycles, then held for a programmable duration. Each enabled channel is corrupted according to one of four modes: stuck-at pattern, XOR bit-flip, LFSR pseudo-random, or masked random flip. Outside an injection window the data passes through with zero latency.

## Interface
- WIDTH, 32, bits per channel
- CHANNELS, 2, number of independent buses (≥1)
- CNT_W, 16, width of delay/duration counters
- LFSR_SEED, 32'hACE1_1234, reset value of the 32-bit LFSR; must be nonzero

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- data_in  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- data_out  out  CHANNELS*WIDTH  passthrough or corrupted data, same packing
- arm  in  1  request to capture config and arm; honoured only in IDLE
- trigger  in  1  starts the delay; honoured only in ARMED
- abort  in  1  cancels any pending or active glitch
- cfg_mode  in  2  0 stuck-at, 1 XOR, 2 random, 3 random AND pattern XOR
- cfg_chan_mask  in  CHANNELS  channels to corrupt
- cfg_delay  in  CNT_W  cycles between trigger and first glitched cycle, minus one
- cfg_duration  in  CNT_W  glitched cycles; 0 treated as 1
- cfg_pattern  in  WIDTH  pattern/mask shared by all channels
- busy  out  1  state ≠ IDLE
- glitch_active  out  1  state = INJECT
- done  out  1  one-cycle pulse when an injection window completes normally
- glitch_count  out  8  saturating count of completed windows

## Operation
- FSM states: IDLE, ARMED, DELAY, INJECT, DONE.
- IDLE, arm=1: latch all cfg_* into shadow registers, go to ARMED. cfg_* are ignored at all other times.
- ARMED, trigger=1: load the delay counter with the shadow delay, go to DELAY.
- DELAY: if counter = 0, load the duration counter with max(duration,1)−1 and go to INJECT. Otherwise decrement.
- INJECT: if counter = 0, go to DONE. Otherwise decrement.
- DONE: done=1 for this cycle, glitch_count += 1 (saturates at 255), go to IDLE.
- abort=1 in any state other than IDLE: go to IDLE next cycle with no done and no count. abort takes priority over trigger and over counter expiry.
- arm while busy is ignored. trigger outside ARMED is ignored. arm and trigger asserted together in IDLE only arms.
- data_out per channel c is combinational from data_in and registered state. If state ≠ INJECT or cfg_chan_mask[c]=0, data_out = data_in. Otherwise, by mode:
  - stuck-at: pattern
  - XOR: in ^ pattern
  - random: R_c
  - masked random: in ^ (R_c & pattern)
- R_c bit i = lfsr[(i + 8*c) mod 32].
- LFSR: 32-bit Galois, taps 0x80200003, shifts every cycle regardless of state, loads LFSR_SEED on reset.

## Timing
- Reset values: FSM IDLE, all counters 0, shadow registers 0, LFSR = LFSR_SEED, busy=0, glitch_active=0, done=0, glitch_count=0. data_out = data_in from the first cycle after reset.
- Reset asserted mid-window forces passthrough starting the next cycle.
- Trigger sampled at edge T:
  - DELAY occupies cycles T+1 .. T+1+delay.
  - INJECT occupies the following max(duration,1) cycles.
  - DONE occupies the cycle after that.
- With delay=0 and duration=1: DELAY in T+1, INJECT in T+2, done=1 in T+3, busy drops in T+4.
- Passthrough has zero latency. Corruption applies in exactly the cycles where glitch_active=1.
- Counters are unsigned, CNT_W bits. delay = 2^CNT_W−1 is legal and does not wrap.

## Test plan
- Reset, then drive data_in=0x12345678 on channel 0 → data_out equal every cycle, busy=0, glitch_count=0.
- Arm with mode 0, mask 2'b01, delay 0, duration 3, pattern 0xDEADBEEF. Trigger at T → channel 0 = 0xDEADBEEF in T+2..T+4, channel 1 untouched, done in T+5, glitch_count=1.
- Mode 1, pattern 0x0000_0001, data_in 0xFFFF_FFFF, mask 2'b11, delay 4 → both channels show 0xFFFF_FFFE for exactly one cycle at T+6.
- Mode 2 with LFSR_SEED default → glitched values match a reference Galois LFSR model per cycle. Channel 1 matches channel 0 rotated by 8 bits.
- Abort during INJECT, and separately abort coincident with trigger → passthrough next cycle, no done, glitch_count unchanged. arm during DELAY does not change the shadow config.
- Complete 256 windows → glitch_count stays at 255. Reset asserted mid-DELAY → all outputs return to their reset values the next cycle.
